mc_ctrl_fsm_v2: RTL and testbench
=================================

Name: mc_ctrl_fsm_v2

Overview:
Parametrised multi-cycle MIPS control unit, the successor of the current Controller. Adds a memory ready/wait handshake on fetch and data access, and bne/ori/xori/sltiu decode. Adds a retired-instruction counter with an instruction-done pulse. Sits between the instruction register and the multi-cycle datapath (PC, IR, register file, ALU, unified memory).

Parameters:
ALUOP_W, 4, width of ALUOp output
CNT_W, 32, width of retired-instruction counter
STATE_W, 3, width of state register and state_o

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
OpCode  in  6  IR[31:26]
Funct  in  6  IR[5:0]
mem_ready  in  1  memory completes the current read/write this cycle
PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemWrite, MemRead, IRWrite, RegWrite, ExtOp, LuiOp  out  1 each  datapath controls
MemtoReg, RegDst, ALUSrcA, ALUSrcB, PCSource  out  2 each  datapath mux selects
ALUOp  out  ALUOP_W  0 add, 1 sub, 2 R-type by Funct, 3 and, 4 slt, 5 sltu, 6 or, 7 pass-A, 8 xor
state_o  out  STATE_W  current state
instr_done  out  1  one-cycle pulse on the final cycle of each instruction
retired  out  CNT_W  count of completed instructions

Behaviour:
- Single registered state; all outputs are combinational decode of state, OpCode, Funct and mem_ready.
- While reset=1: every output is 0 and retired=0. The next state is IF. Reset mid-instruction abandons it with no write enable leaking.
- States: IF=0, ID=1, EX=2, MEM=3, WB=4, TRAP=5 (feature only). Other codes go to IF.
- IF: MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=add, PCSource=00. IRWrite=PCWrite=mem_ready. Stays in IF until mem_ready=1, then goes to ID.
- ID: ALUSrcA=00, ALUSrcB=11, ExtOp=1 (branch target into ALUOut). Always goes to EX.
- EX, R-type:
  - sll/srl/sra: ALUSrcA=10; other R-type: ALUSrcA=01. ALUSrcB=00, ALUOp=2. Goes to WB.
  - jr: ALUSrcA=01, ALUOp=pass-A, PCSource=00, PCWrite=1. Goes to IF.
  - jalr: as jr, plus RegWrite=1, RegDst=01, MemtoReg=10. Goes to IF.
- EX, I-type (lw/sw/lui/addi/addiu/andi/ori/xori/slti/sltiu): ALUSrcA=01, ALUSrcB=10. ExtOp=0 for andi/ori/xori, 1 otherwise. LuiOp=1 for lui only. ALUOp per opcode. lw/sw go to MEM; others go to WB.
- EX, beq: ALUSrcA=01, ALUSrcB=00, ALUOp=sub, PCSource=01, PCWriteCond=1. Goes to IF.
- EX, bne: identical to beq but PCWriteCondNe=1 instead of PCWriteCond.
- EX, j: PCWrite=1, PCSource=10. Goes to IF.
- EX, jal: as j, plus RegWrite=1, RegDst=10, MemtoReg=10. Goes to IF.
- EX, unknown opcode: goes to IF, no write enables.
- MEM: IorD=1. lw: MemRead=1, goes to WB on mem_ready. sw: MemWrite=1, goes to IF on mem_ready. Both hold the state while mem_ready=0.
- WB: RegWrite=1.
  - lw: RegDst=00, MemtoReg=00.
  - R-type: RegDst=01, MemtoReg=01.
  - I-type ALU: RegDst=00, MemtoReg=01.
  - Always goes to IF.
- instr_done=1 in any state whose next state is IF and that is not itself IF.
- retired increments by 1 on each clock edge where instr_done=1. It wraps from 2^CNT_W-1 to 0.
- Latency with mem_ready tied high:
  - R-type/ALU-immediate and sw: 4 cycles.
  - lw: 5 cycles.
  - branch/jump: 3 cycles.
  - Each low mem_ready cycle adds one.
- Unknown opcode in EX still counts as retired.

Optional Feature:
Macro MC_CTRL_TRAP_EN.
- Defined: an unknown OpCode, or unknown Funct under OpCode 0, goes from EX to TRAP instead of IF. TRAP asserts PCWrite=1 and PCSource=11 (exception vector) for one cycle, then goes to IF. TRAP raises instr_done but does not increment retired.
- Undefined: no TRAP state; unknowns behave as a no-op, and PCSource never equals 11.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state encodings
  - opcode/funct constants
  - ALUOp codes
  - mux-select encodings for MemtoReg, RegDst, ALUSrcA/B, PCSource
- One sub-module, mc_ctrl_decode: combinational decode from OpCode/Funct to an instruction class (RTYPE, SHIFT, JR, JALR, LOAD, STORE, ALUIMM, BEQ, BNE, J, JAL, ILLEGAL), plus ALUOp, ExtOp and LuiOp.

Test Plan:
- Reset held 3 cycles mid-lw, mem_ready=1 → all outputs 0; state_o=0 on the first cycle after release; retired=0.
- add (OpCode 0x00, Funct 0x20), mem_ready=1 → states 0,1,2,4; WB has RegWrite=1, RegDst=01, MemtoReg=01; retired=1.
- lw with mem_ready low 2 cycles in IF and 3 in MEM → 10 cycles total; IRWrite high only on the IF ready cycle; WB has MemtoReg=00.
- bne (0x05) then beq (0x04) → EX asserts PCWriteCondNe=1 and PCWriteCond=1 respectively, ALUOp=1; 3 cycles each.
- jal (0x03) then jalr (0x00/0x09) → EX has PCWrite=1, RegWrite=1, MemtoReg=10; RegDst=10 and 01 respectively.
- CNT_W=4, run 17 R-types → retired wraps to 1. Illegal OpCode 0x3F with MC_CTRL_TRAP_EN → TRAP state with PCSource=11; retired unchanged.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_pkg
// Purpose  : Shared encodings for the multi-cycle MIPS control unit.
// Revision : 2.0 - handshake, bne/ori/xori/sltiu, retired counter
// ============================================================================
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_TRAP = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        IC_RTYPE, IC_SHIFT, IC_JR, IC_JALR, IC_LOAD, IC_STORE,
        IC_ALUIMM, IC_BEQ, IC_BNE, IC_J, IC_JAL, IC_ILLEGAL
    } instr_class_t;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_JAL   = 6'h03;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_ADDIU = 6'h09;
    localparam logic [5:0] c_OP_SLTI  = 6'h0A;
    localparam logic [5:0] c_OP_SLTIU = 6'h0B;
    localparam logic [5:0] c_OP_ANDI  = 6'h0C;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_XORI  = 6'h0E;
    localparam logic [5:0] c_OP_LUI   = 6'h0F;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    localparam logic [5:0] c_FN_SLL  = 6'h00;
    localparam logic [5:0] c_FN_SRL  = 6'h02;
    localparam logic [5:0] c_FN_SRA  = 6'h03;
    localparam logic [5:0] c_FN_SLLV = 6'h04;
    localparam logic [5:0] c_FN_SRLV = 6'h06;
    localparam logic [5:0] c_FN_SRAV = 6'h07;
    localparam logic [5:0] c_FN_JR   = 6'h08;
    localparam logic [5:0] c_FN_JALR = 6'h09;
    localparam logic [5:0] c_FN_ADD  = 6'h20;
    localparam logic [5:0] c_FN_ADDU = 6'h21;
    localparam logic [5:0] c_FN_SUB  = 6'h22;
    localparam logic [5:0] c_FN_SUBU = 6'h23;
    localparam logic [5:0] c_FN_AND  = 6'h24;
    localparam logic [5:0] c_FN_OR   = 6'h25;
    localparam logic [5:0] c_FN_XOR  = 6'h26;
    localparam logic [5:0] c_FN_NOR  = 6'h27;
    localparam logic [5:0] c_FN_SLT  = 6'h2A;
    localparam logic [5:0] c_FN_SLTU = 6'h2B;

    localparam logic [3:0] c_ALU_ADD   = 4'd0;
    localparam logic [3:0] c_ALU_SUB   = 4'd1;
    localparam logic [3:0] c_ALU_FUNCT = 4'd2;
    localparam logic [3:0] c_ALU_AND   = 4'd3;
    localparam logic [3:0] c_ALU_SLT   = 4'd4;
    localparam logic [3:0] c_ALU_SLTU  = 4'd5;
    localparam logic [3:0] c_ALU_OR    = 4'd6;
    localparam logic [3:0] c_ALU_PASSA = 4'd7;
    localparam logic [3:0] c_ALU_XOR   = 4'd8;

    localparam logic [1:0] c_M2R_MEM   = 2'b00;
    localparam logic [1:0] c_M2R_ALU   = 2'b01;
    localparam logic [1:0] c_M2R_PC    = 2'b10;
    localparam logic [1:0] c_RDST_RT   = 2'b00;
    localparam logic [1:0] c_RDST_RD   = 2'b01;
    localparam logic [1:0] c_RDST_RA   = 2'b10;
    localparam logic [1:0] c_SRCA_PC   = 2'b00;
    localparam logic [1:0] c_SRCA_REG  = 2'b01;
    localparam logic [1:0] c_SRCA_SHMT = 2'b10;
    localparam logic [1:0] c_SRCB_REG  = 2'b00;
    localparam logic [1:0] c_SRCB_FOUR = 2'b01;
    localparam logic [1:0] c_SRCB_IMM  = 2'b10;
    localparam logic [1:0] c_SRCB_BOFF = 2'b11;
    localparam logic [1:0] c_PCS_ALU   = 2'b00;
    localparam logic [1:0] c_PCS_OUT   = 2'b01;
    localparam logic [1:0] c_PCS_JUMP  = 2'b10;
    localparam logic [1:0] c_PCS_EXC   = 2'b11;

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_decode
// Purpose  : OpCode/Funct to instruction class, ALU operation and imm controls.
// Revision : 2.0 - adds bne/ori/xori/sltiu
// ============================================================================
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0]   OpCode,
    input  logic [5:0]   Funct,
    output instr_class_t iclass,
    output logic [3:0]   alu_op,
    output logic         ext_op,
    output logic         lui_op
);

    always_comb begin
        iclass = IC_ILLEGAL;
        alu_op = c_ALU_ADD;
        ext_op = 1'b1;
        lui_op = 1'b0;
        case (OpCode)
            c_OP_RTYPE: begin
                case (Funct)
                    c_FN_SLL, c_FN_SRL, c_FN_SRA: begin
                        iclass = IC_SHIFT;
                        alu_op = c_ALU_FUNCT;
                    end
                    c_FN_JR: begin
                        iclass = IC_JR;
                        alu_op = c_ALU_PASSA;
                    end
                    c_FN_JALR: begin
                        iclass = IC_JALR;
                        alu_op = c_ALU_PASSA;
                    end
                    c_FN_SLLV, c_FN_SRLV, c_FN_SRAV, c_FN_ADD, c_FN_ADDU,
                    c_FN_SUB, c_FN_SUBU, c_FN_AND, c_FN_OR, c_FN_XOR,
                    c_FN_NOR, c_FN_SLT, c_FN_SLTU: begin
                        iclass = IC_RTYPE;
                        alu_op = c_ALU_FUNCT;
                    end
                    default: iclass = IC_ILLEGAL;
                endcase
            end
            c_OP_LW:    iclass = IC_LOAD;
            c_OP_SW:    iclass = IC_STORE;
            c_OP_ADDI,
            c_OP_ADDIU: iclass = IC_ALUIMM;
            c_OP_LUI: begin
                iclass = IC_ALUIMM;
                lui_op = 1'b1;
            end
            c_OP_SLTI: begin
                iclass = IC_ALUIMM;
                alu_op = c_ALU_SLT;
            end
            c_OP_SLTIU: begin
                iclass = IC_ALUIMM;
                alu_op = c_ALU_SLTU;
            end
            // logical immediates are zero-extended
            c_OP_ANDI: begin
                iclass = IC_ALUIMM;
                alu_op = c_ALU_AND;
                ext_op = 1'b0;
            end
            c_OP_ORI: begin
                iclass = IC_ALUIMM;
                alu_op = c_ALU_OR;
                ext_op = 1'b0;
            end
            c_OP_XORI: begin
                iclass = IC_ALUIMM;
                alu_op = c_ALU_XOR;
                ext_op = 1'b0;
            end
            c_OP_BEQ: begin
                iclass = IC_BEQ;
                alu_op = c_ALU_SUB;
            end
            c_OP_BNE: begin
                iclass = IC_BNE;
                alu_op = c_ALU_SUB;
            end
            c_OP_J:   iclass = IC_J;
            c_OP_JAL: iclass = IC_JAL;
            default:  iclass = IC_ILLEGAL;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_ctrl_fsm_v2.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_fsm_v2
// Purpose  : Multi-cycle MIPS control FSM with memory handshake and retire
//            counter. Optional trap state enabled by MC_CTRL_TRAP_EN.
// Revision : 2.0 - successor of Controller
// ============================================================================
module mc_ctrl_fsm_v2
    import mc_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 32,
    parameter int STATE_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         OpCode,
    input  logic [5:0]         Funct,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               PCWriteCondNe,
    output logic               IorD,
    output logic               MemWrite,
    output logic               MemRead,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic               ExtOp,
    output logic               LuiOp,
    output logic [1:0]         MemtoReg,
    output logic [1:0]         RegDst,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSource,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [STATE_W-1:0] state_o,
    output logic               instr_done,
    output logic [CNT_W-1:0]   retired
);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_retired;
    instr_class_t     w_iclass;
    logic [3:0]       w_dec_alu;
    logic             w_dec_ext;
    logic             w_dec_lui;

    mc_ctrl_decode u_decode (
        .OpCode (OpCode),
        .Funct  (Funct),
        .iclass (w_iclass),
        .alu_op (w_dec_alu),
        .ext_op (w_dec_ext),
        .lui_op (w_dec_lui)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IF;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            // a trap ends the instruction but does not retire it
            if (instr_done && r_state != S_TRAP)
                r_retired <= r_retired + CNT_W'(1);
        end
    end

    always_comb begin
        w_next        = S_IF;
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        PCWriteCondNe = 1'b0;
        IorD          = 1'b0;
        MemWrite      = 1'b0;
        MemRead       = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        ExtOp         = 1'b0;
        LuiOp         = 1'b0;
        MemtoReg      = c_M2R_MEM;
        RegDst        = c_RDST_RT;
        ALUSrcA       = c_SRCA_PC;
        ALUSrcB       = c_SRCB_REG;
        PCSource      = c_PCS_ALU;
        ALUOp         = ALUOP_W'(c_ALU_ADD);
        case (r_state)
            S_IF: begin
                MemRead = 1'b1;
                ALUSrcB = c_SRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                w_next  = mem_ready ? S_ID : S_IF;
            end
            S_ID: begin
                ALUSrcB = c_SRCB_BOFF;
                ExtOp   = 1'b1;
                w_next  = S_EX;
            end
            S_EX: begin
                case (w_iclass)
                    IC_RTYPE, IC_SHIFT: begin
                        ALUSrcA = (w_iclass == IC_SHIFT) ? c_SRCA_SHMT : c_SRCA_REG;
                        ALUOp   = ALUOP_W'(w_dec_alu);
                        w_next  = S_WB;
                    end
                    IC_JR, IC_JALR: begin
                        ALUSrcA = c_SRCA_REG;
                        ALUOp   = ALUOP_W'(w_dec_alu);
                        PCWrite = 1'b1;
                        if (w_iclass == IC_JALR) begin
                            RegWrite = 1'b1;
                            RegDst   = c_RDST_RD;
                            MemtoReg = c_M2R_PC;
                        end
                    end
                    IC_LOAD, IC_STORE, IC_ALUIMM: begin
                        ALUSrcA = c_SRCA_REG;
                        ALUSrcB = c_SRCB_IMM;
                        ExtOp   = w_dec_ext;
                        LuiOp   = w_dec_lui;
                        ALUOp   = ALUOP_W'(w_dec_alu);
                        w_next  = (w_iclass == IC_ALUIMM) ? S_WB : S_MEM;
                    end
                    IC_BEQ, IC_BNE: begin
                        ALUSrcA       = c_SRCA_REG;
                        ALUOp         = ALUOP_W'(w_dec_alu);
                        PCSource      = c_PCS_OUT;
                        PCWriteCond   = (w_iclass == IC_BEQ);
                        PCWriteCondNe = (w_iclass == IC_BNE);
                    end
                    IC_J, IC_JAL: begin
                        PCWrite  = 1'b1;
                        PCSource = c_PCS_JUMP;
                        if (w_iclass == IC_JAL) begin
                            RegWrite = 1'b1;
                            RegDst   = c_RDST_RA;
                            MemtoReg = c_M2R_PC;
                        end
                    end
                    default: begin
`ifdef MC_CTRL_TRAP_EN
                        w_next = S_TRAP;
`else
                        w_next = S_IF;
`endif
                    end
                endcase
            end
            S_MEM: begin
                IorD = 1'b1;
                if (w_iclass == IC_LOAD) begin
                    MemRead = 1'b1;
                    w_next  = mem_ready ? S_WB : S_MEM;
                end else if (w_iclass == IC_STORE) begin
                    MemWrite = 1'b1;
                    w_next   = mem_ready ? S_IF : S_MEM;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                if (w_iclass == IC_RTYPE || w_iclass == IC_SHIFT) begin
                    RegDst   = c_RDST_RD;
                    MemtoReg = c_M2R_ALU;
                end else if (w_iclass == IC_ALUIMM) begin
                    MemtoReg = c_M2R_ALU;
                end
            end
`ifdef MC_CTRL_TRAP_EN
            S_TRAP: begin
                PCWrite  = 1'b1;
                PCSource = c_PCS_EXC;
            end
`endif
            default: w_next = S_IF;
        endcase

        instr_done = (w_next == S_IF) && (r_state != S_IF);

        // reset forces every control low, even mid-instruction
        if (reset) begin
            PCWrite       = 1'b0;
            PCWriteCond   = 1'b0;
            PCWriteCondNe = 1'b0;
            IorD          = 1'b0;
            MemWrite      = 1'b0;
            MemRead       = 1'b0;
            IRWrite       = 1'b0;
            RegWrite      = 1'b0;
            ExtOp         = 1'b0;
            LuiOp         = 1'b0;
            MemtoReg      = 2'b00;
            RegDst        = 2'b00;
            ALUSrcA       = 2'b00;
            ALUSrcB       = 2'b00;
            PCSource      = 2'b00;
            ALUOp         = '0;
            instr_done    = 1'b0;
        end
    end

    assign state_o = reset ? '0 : STATE_W'(r_state);
    assign retired = reset ? '0 : r_retired;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_fsm_v2.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_ctrl_fsm_v2
// Purpose  : Directed self-checking bench for mc_ctrl_fsm_v2 (CNT_W=4).
// Revision : 2.0
// ============================================================================
module tb_mc_ctrl_fsm_v2;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] OpCode, Funct;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemWrite, MemRead;
    logic       IRWrite, RegWrite, ExtOp, LuiOp, instr_done;
    logic [1:0] MemtoReg, RegDst, ALUSrcA, ALUSrcB, PCSource;
    logic [3:0] ALUOp;
    logic [2:0] state_o;
    logic [3:0] retired;

    int         n_chk = 0;
    int         n_pass = 0;
    int         n_cyc;
    int         exp_ret;
    logic [24:0] tr_ctl [0:31];
    logic [2:0]  tr_st  [0:31];
    logic [31:0] w_tmp;

    always #5 clk = ~clk;

    mc_ctrl_fsm_v2 #(.ALUOP_W(4), .CNT_W(4), .STATE_W(3)) dut (
        .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .PCWriteCondNe(PCWriteCondNe), .IorD(IorD), .MemWrite(MemWrite),
        .MemRead(MemRead), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ExtOp(ExtOp), .LuiOp(LuiOp), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .ALUOp(ALUOp), .state_o(state_o), .instr_done(instr_done),
        .retired(retired)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // Bit order: pcw pcwc pcwcne iord memw memr irw regw ext lui m2r rdst sa sb pcs alu done
    function automatic logic [24:0] ctl(input logic pcw, pcwc, pcwcne, iord, memw, memr,
                                        input logic irw, regw, ext, lui,
                                        input logic [1:0] m2r, rdst, sa, sb, pcs,
                                        input logic [3:0] alu, input logic done);
        return {pcw, pcwc, pcwcne, iord, memw, memr, irw, regw, ext, lui,
                m2r, rdst, sa, sb, pcs, alu, done};
    endfunction

    function automatic logic [24:0] obs();
        return {PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemWrite, MemRead,
                IRWrite, RegWrite, ExtOp, LuiOp, MemtoReg, RegDst, ALUSrcA,
                ALUSrcB, PCSource, ALUOp, instr_done};
    endfunction

    // Runs one instruction from IF, recording per-cycle state and controls.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int if_wait, input int mem_wait);
        int  iw = if_wait;
        int  mw = mem_wait;
        bit  done = 1'b0;
        OpCode = op;
        Funct  = fn;
        n_cyc  = 0;
        while (!done && n_cyc < 32) begin
            mem_ready = 1'b1;
            if (state_o == 3'd0 && iw > 0) begin mem_ready = 1'b0; iw--; end
            if (state_o == 3'd3 && mw > 0) begin mem_ready = 1'b0; mw--; end
            #1;
            tr_st[n_cyc]  = state_o;
            tr_ctl[n_cyc] = obs();
            done = instr_done;
            n_cyc++;
            @(posedge clk); #1;
        end
        if (!done) check_eq("instr_timeout", 32'(n_cyc), 32'hFFFF_FFFF);
    endtask

    task automatic retire_one();
        exp_ret = (exp_ret + 1) % 16;
    endtask

    initial begin
        reset = 1'b1; OpCode = 6'h00; Funct = 6'h00; mem_ready = 1'b1; exp_ret = 0;
        repeat (2) @(posedge clk);
        #1;
        // Start a lw and reset it while it is in MEM
        reset = 1'b0; OpCode = 6'h23;
        repeat (3) begin @(posedge clk); #1; end
        check_eq("lw_in_mem", 32'(state_o), 32'd3);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("rst_ctl", 32'(obs()), 32'd0);
            check_eq("rst_state", 32'(state_o), 32'd0);
            check_eq("rst_retired", 32'(retired), 32'd0);
            @(posedge clk); #1;
        end
        reset = 1'b0;
        #1;
        check_eq("post_rst_state", 32'(state_o), 32'd0);
        check_eq("post_rst_retired", 32'(retired), 32'd0);

        // add
        run_instr(6'h00, 6'h20, 0, 0); retire_one();
        check_eq("add_cycles", 32'(n_cyc), 32'd4);
        check_eq("add_states", 32'({tr_st[0], tr_st[1], tr_st[2], tr_st[3]}), 32'({3'd0, 3'd1, 3'd2, 3'd4}));
        check_eq("add_if", 32'(tr_ctl[0]), 32'(ctl(1,0,0,0,0,1,1,0,0,0,2'b00,2'b00,2'b00,2'b01,2'b00,4'd0,0)));
        check_eq("add_id", 32'(tr_ctl[1]), 32'(ctl(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,2'b11,2'b00,4'd0,0)));
        check_eq("add_ex", 32'(tr_ctl[2]), 32'(ctl(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b01,2'b00,2'b00,4'd2,0)));
        check_eq("add_wb", 32'(tr_ctl[3]), 32'(ctl(0,0,0,0,0,0,0,1,0,0,2'b01,2'b01,2'b00,2'b00,2'b00,4'd0,1)));
        check_eq("add_retired", 32'(retired), 32'(exp_ret));

        // lw with 2 IF waits and 3 MEM waits
        run_instr(6'h23, 6'h00, 2, 3); retire_one();
        check_eq("lw_cycles", 32'(n_cyc), 32'd10);
        w_tmp = '0;
        for (int i = 0; i < 10; i++) w_tmp[i] = tr_ctl[i][18];
        check_eq("lw_irwrite_mask", w_tmp, 32'h0000_0004);
        check_eq("lw_states", 32'({tr_st[2], tr_st[3], tr_st[4], tr_st[5], tr_st[8], tr_st[9]}),
                 32'({3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4}));
        check_eq("lw_ex", 32'(tr_ctl[4]), 32'(ctl(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b01,2'b10,2'b00,4'd0,0)));
        check_eq("lw_mem_wait", 32'(tr_ctl[5]), 32'(ctl(0,0,0,1,0,1,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,4'd0,0)));
        check_eq("lw_wb", 32'(tr_ctl[9]), 32'(ctl(0,0,0,0,0,0,0,1,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,4'd0,1)));
        check_eq("lw_retired", 32'(retired), 32'(exp_ret));

        // bne then beq
        run_instr(6'h05, 6'h00, 0, 0); retire_one();
        check_eq("bne_cycles", 32'(n_cyc), 32'd3);
        check_eq("bne_ex", 32'(tr_ctl[2]), 32'(ctl(0,0,1,0,0,0,0,0,0,0,2'b00,2'b00,2'b01,2'b00,2'b01,4'd1,1)));
        run_instr(6'h04, 6'h00, 0, 0); retire_one();
        check_eq("beq_cycles", 32'(n_cyc), 32'd3);
        check_eq("beq_ex", 32'(tr_ctl[2]), 32'(ctl(0,1,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b01,2'b00,2'b01,4'd1,1)));

        // jal then jalr
        run_instr(6'h03, 6'h00, 0, 0); retire_one();
        check_eq("jal_cycles", 32'(n_cyc), 32'd3);
        check_eq("jal_ex", 32'(tr_ctl[2]), 32'(ctl(1,0,0,0,0,0,0,1,0,0,2'b10,2'b10,2'b00,2'b00,2'b10,4'd0,1)));
        run_instr(6'h00, 6'h09, 0, 0); retire_one();
        check_eq("jalr_cycles", 32'(n_cyc), 32'd3);
        check_eq("jalr_ex", 32'(tr_ctl[2]), 32'(ctl(1,0,0,0,0,0,0,1,0,0,2'b10,2'b01,2'b01,2'b00,2'b00,4'd7,1)));
        check_eq("jump_retired", 32'(retired), 32'(exp_ret));

        // immediate ALU ops and shift
        run_instr(6'h0D, 6'h00, 0, 0); retire_one();
        check_eq("ori_ex", 32'(tr_ctl[2]), 32'(ctl(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b01,2'b10,2'b00,4'd6,0)));
        check_eq("ori_wb", 32'(tr_ctl[3]), 32'(ctl(0,0,0,0,0,0,0,1,0,0,2'b01,2'b00,2'b00,2'b00,2'b00,4'd0,1)));
        run_instr(6'h0E, 6'h00, 0, 0); retire_one();
        check_eq("xori_ex", 32'(tr_ctl[2]), 32'(ctl(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b01,2'b10,2'b00,4'd8,0)));
        run_instr(6'h0B, 6'h00, 0, 0); retire_one();
        check_eq("sltiu_ex", 32'(tr_ctl[2]), 32'(ctl(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b01,2'b10,2'b00,4'd5,0)));
        run_instr(6'h0F, 6'h00, 0, 0); retire_one();
        check_eq("lui_ex", 32'(tr_ctl[2]), 32'(ctl(0,0,0,0,0,0,0,0,1,1,2'b00,2'b00,2'b01,2'b10,2'b00,4'd0,0)));
        run_instr(6'h00, 6'h00, 0, 0); retire_one();
        check_eq("sll_ex", 32'(tr_ctl[2]), 32'(ctl(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,2'b00,2'b00,4'd2,0)));
        check_eq("sll_cycles", 32'(n_cyc), 32'd4);

        // sw with one MEM wait
        run_instr(6'h2B, 6'h00, 0, 1); retire_one();
        check_eq("sw_cycles", 32'(n_cyc), 32'd5);
        check_eq("sw_mem_wait", 32'(tr_ctl[3]), 32'(ctl(0,0,0,1,1,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,4'd0,0)));
        check_eq("sw_mem_done", 32'(tr_ctl[4]), 32'(ctl(0,0,0,1,1,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,4'd0,1)));
        check_eq("sw_retired", 32'(retired), 32'(exp_ret));

        // illegal opcode and illegal funct
`ifdef MC_CTRL_TRAP_EN
        run_instr(6'h3F, 6'h00, 0, 0);
        check_eq("trap_cycles", 32'(n_cyc), 32'd4);
        check_eq("trap_states", 32'({tr_st[2], tr_st[3]}), 32'({3'd2, 3'd5}));
        check_eq("trap_ex", 32'(tr_ctl[2]), 32'd0);
        check_eq("trap_ctl", 32'(tr_ctl[3]), 32'(ctl(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b11,4'd0,1)));
        check_eq("trap_retired", 32'(retired), 32'(exp_ret));
        run_instr(6'h00, 6'h3F, 0, 0);
        check_eq("trap_fn_state", 32'(tr_st[3]), 32'd5);
        check_eq("trap_fn_retired", 32'(retired), 32'(exp_ret));
`else
        run_instr(6'h3F, 6'h00, 0, 0); retire_one();
        check_eq("illegal_cycles", 32'(n_cyc), 32'd3);
        check_eq("illegal_ex", 32'(tr_ctl[2]), 32'(ctl(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,4'd0,1)));
        check_eq("illegal_retired", 32'(retired), 32'(exp_ret));
        run_instr(6'h00, 6'h3F, 0, 0); retire_one();
        check_eq("illegal_fn_ex", 32'(tr_ctl[2]), 32'(ctl(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,4'd0,1)));
        check_eq("illegal_fn_retired", 32'(retired), 32'(exp_ret));
`endif

        // counter wrap: 17 R-types from zero on a 4-bit counter
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            run_instr(6'h00, 6'h20, 0, 0);
            if (i == 15) check_eq("wrap_15", 32'(retired), 32'd15);
            if (i == 16) check_eq("wrap_16", 32'(retired), 32'd0);
        end
        check_eq("wrap_17", 32'(retired), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
